// File: rtl/wwdg_pkg.sv
// Shared window-watchdog definitions: register offsets, CR/CFG field positions, feeder states.
package wwdg_pkg;

    localparam logic [31:0] CR_OFS  = 32'h0000_0000;
    localparam logic [31:0] CFG_OFS = 32'h0000_0004;
    localparam logic [31:0] ST_OFS  = 32'h0000_0008;

    localparam int CR_WDGA_BIT = 7;
    localparam int CR_T6_BIT   = 6;
    localparam int CR_CNT_MSB  = 6;

    localparam int CFG_EWI_BIT = 9;
    localparam int CFG_PRE_MSB = 8;
    localparam int CFG_PRE_LSB = 7;
    localparam int CFG_WIN_MSB = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ARM,
        S_WR_CFG,
        S_WAIT,
        S_RD_CR,
        S_WR_REF,
        S_FAULT
    } feeder_state_e;

    // A refresh is only legal once the down-counter has fallen to or below the window value.
    function automatic logic in_window(input logic [6:0] cnt, input logic [6:0] win);
        return cnt <= win;
    endfunction

endpackage

// File: rtl/wb_single_xfer.sv
// One Wishbone classic transfer at a time with registered bus outputs and same-edge completion.
// Define WWDG_FEEDER_TMO_EN to abandon a transfer that sees no ack within TMO_CYC cycles.
module wb_single_xfer #(
    parameter int TMO_CYC = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] req_adr,
    input  logic [9:0]  req_dat,
    input  logic        req_we,
    output logic        done,
    output logic        tmo,
    output logic [9:0]  rdata,
    output logic [31:0] adr_m2s,
    output logic [9:0]  dat_m2s,
    output logic        cyc_m2s,
    output logic        stb_m2s,
    output logic        we_m2s,
    input  logic [9:0]  dat_s2m,
    input  logic        ack_s2m
);

    logic expire;

    assign done  = cyc_m2s && ack_s2m;
    assign tmo   = expire;
    assign rdata = dat_s2m;

`ifdef WWDG_FEEDER_TMO_EN
    logic [15:0] wait_cnt;

    assign expire = cyc_m2s && !ack_s2m && (wait_cnt == 16'(TMO_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || !cyc_m2s) wait_cnt <= '0;
        else                 wait_cnt <= wait_cnt + 16'd1;
    end
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TMO_CYC == 0);
    assign expire = 1'b0;
`endif

    // NOTE: bus outputs are flops updated with <= so the responder never sees a combinational glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            adr_m2s <= '0;
            dat_m2s <= '0;
            we_m2s  <= 1'b0;
            cyc_m2s <= 1'b0;
            stb_m2s <= 1'b0;
        end else if (!cyc_m2s) begin
            if (req) begin
                adr_m2s <= req_adr;
                dat_m2s <= req_dat;
                we_m2s  <= req_we;
                cyc_m2s <= 1'b1;
                stb_m2s <= 1'b1;
            end
        end else if (done || expire) begin
            cyc_m2s <= 1'b0;
            stb_m2s <= 1'b0;
        end
    end

endmodule

// File: rtl/wwdg_feeder.sv
// Window-watchdog feeder: arms the watchdog, polls CR, refreshes inside the window after a kick.
// Define WWDG_FEEDER_TMO_EN to enable the per-transfer ack timeout and the tmo_err flag.
module wwdg_feeder
    import wwdg_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h0110_0000,
    parameter logic [9:0]  CFG_VAL  = 10'h27F,
    parameter logic [7:0]  ARM_VAL  = 8'hFF,
    parameter logic [7:0]  REF_VAL  = 8'hFF,
    parameter int          POLL_CYC = 16,
    parameter int          TMO_CYC  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        kick,
    output logic [31:0] adr_m2s,
    output logic [9:0]  dat_m2s,
    output logic        cyc_m2s,
    output logic        stb_m2s,
    output logic        we_m2s,
    input  logic [9:0]  dat_s2m,
    input  logic        ack_s2m,
    output logic        armed,
    output logic        busy,
    output logic        missed,
    output logic        tmo_err,
    output logic [15:0] ref_cnt
);

    localparam logic [15:0] POLL_LOAD = 16'(POLL_CYC - 1);

    feeder_state_e state;
    logic          req;
    logic          req_we;
    logic [31:0]   req_adr;
    logic [9:0]    req_dat;
    logic [15:0]   poll_cnt;
    logic          kick_pend;
    logic          xfer_done;
    logic          xfer_tmo;
    logic [9:0]    xfer_rdata;
    logic          unused_rdata;

    wb_single_xfer #(
        .TMO_CYC (TMO_CYC)
    ) u_xfer (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_adr (req_adr),
        .req_dat (req_dat),
        .req_we  (req_we),
        .done    (xfer_done),
        .tmo     (xfer_tmo),
        .rdata   (xfer_rdata),
        .adr_m2s (adr_m2s),
        .dat_m2s (dat_m2s),
        .cyc_m2s (cyc_m2s),
        .stb_m2s (stb_m2s),
        .we_m2s  (we_m2s),
        .dat_s2m (dat_s2m),
        .ack_s2m (ack_s2m)
    );

    assign busy         = cyc_m2s;
    assign unused_rdata = ^xfer_rdata[9:7];

`ifdef WWDG_FEEDER_TMO_EN
    always_ff @(posedge clk) begin
        if (rst)           tmo_err <= 1'b0;
        else if (xfer_tmo) tmo_err <= 1'b1;
    end
`else
    assign tmo_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            req       <= 1'b0;
            req_we    <= 1'b0;
            req_adr   <= '0;
            req_dat   <= '0;
            poll_cnt  <= '0;
            kick_pend <= 1'b0;
            armed     <= 1'b0;
            missed    <= 1'b0;
            ref_cnt   <= '0;
        end else begin
            req <= 1'b0;
            if (kick) kick_pend <= 1'b1;

            case (state)
                S_IDLE: if (start) begin
                    // CR goes first: writing CFG while CR still reads 7Fh would trip the window check.
                    req     <= 1'b1;
                    req_we  <= 1'b1;
                    req_adr <= BASE_ADR + CR_OFS;
                    req_dat <= {2'b00, ARM_VAL};
                    state   <= S_WR_ARM;
                end
                S_WR_ARM: if (xfer_done) begin
                    req     <= 1'b1;
                    req_we  <= 1'b1;
                    req_adr <= BASE_ADR + CFG_OFS;
                    req_dat <= CFG_VAL;
                    state   <= S_WR_CFG;
                end
                S_WR_CFG: if (xfer_done) begin
                    armed    <= 1'b1;
                    poll_cnt <= POLL_LOAD;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (poll_cnt == 16'd0) begin
                        req     <= 1'b1;
                        req_we  <= 1'b0;
                        req_adr <= BASE_ADR + CR_OFS;
                        req_dat <= '0;
                        state   <= S_RD_CR;
                    end else begin
                        poll_cnt <= poll_cnt - 16'd1;
                    end
                end
                S_RD_CR: if (xfer_done) begin
                    if (!xfer_rdata[CR_T6_BIT]) begin
                        missed <= 1'b1;
                        state  <= S_FAULT;
                    end else if (kick_pend &&
                                 in_window(xfer_rdata[CR_CNT_MSB:0], CFG_VAL[CFG_WIN_MSB:0])) begin
                        req     <= 1'b1;
                        req_we  <= 1'b1;
                        req_adr <= BASE_ADR + CR_OFS;
                        req_dat <= {2'b00, REF_VAL};
                        state   <= S_WR_REF;
                    end else begin
                        poll_cnt <= POLL_LOAD;
                        state    <= S_WAIT;
                    end
                end
                S_WR_REF: if (xfer_done) begin
                    // A kick landing on the ack edge belongs to the next window.
                    kick_pend <= kick;
                    if (ref_cnt != 16'hFFFF) ref_cnt <= ref_cnt + 16'd1;
                    poll_cnt  <= POLL_LOAD;
                    state     <= S_WAIT;
                end
                S_FAULT: state <= S_FAULT;
                default: state <= S_FAULT;
            endcase

            if (xfer_tmo) state <= S_FAULT;
        end
    end

endmodule

// File: tb/tb_wwdg_feeder.sv
// Scoreboard bench for wwdg_feeder: stimulus queues expected bus transfers, a responder/monitor
// process acks them and compares. Timeout scenarios run when WWDG_FEEDER_TMO_EN is defined.
module tb_wwdg_feeder;

    localparam logic [31:0] BASE     = 32'h0110_0000;
    localparam logic [31:0] CR_ADR   = BASE;
    localparam logic [31:0] CFG_ADR  = BASE + 32'h4;
    localparam int          POLL_CYC = 16;
    localparam int          TMO_CYC  = 8;
    // WAIT spends POLL_CYC cycles, then one cycle to register the request.
    localparam int          POLL_GAP = POLL_CYC + 1;

    typedef struct packed {
        logic [31:0] adr;
        logic [9:0]  dat;
        logic        we;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        kick;
    logic [31:0] adr_m2s;
    logic [9:0]  dat_m2s;
    logic        cyc_m2s;
    logic        stb_m2s;
    logic        we_m2s;
    logic [9:0]  dat_s2m;
    logic        ack_s2m;
    logic        armed;
    logic        busy;
    logic        missed;
    logic        tmo_err;
    logic [15:0] ref_cnt;

    xfer_t       exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc_no = 0;
    int          ack_cnt = 0;
    int          start_cnt = 0;
    int          last_ack_cyc = 0;
    int          last_start_cyc = 0;
    int          last_drop_cyc = 0;
    logic        no_ack = 1'b0;
    int          ack_delay = 0;
    logic [9:0]  rd_data = 10'h07F;

    wwdg_feeder #(
        .BASE_ADR (BASE),
        .CFG_VAL  (10'h27F),
        .ARM_VAL  (8'hFF),
        .REF_VAL  (8'hFF),
        .POLL_CYC (POLL_CYC),
        .TMO_CYC  (TMO_CYC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .kick    (kick),
        .adr_m2s (adr_m2s),
        .dat_m2s (dat_m2s),
        .cyc_m2s (cyc_m2s),
        .stb_m2s (stb_m2s),
        .we_m2s  (we_m2s),
        .dat_s2m (dat_s2m),
        .ack_s2m (ack_s2m),
        .armed   (armed),
        .busy    (busy),
        .missed  (missed),
        .tmo_err (tmo_err),
        .ref_cnt (ref_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_no <= cyc_no + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_wait(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait budget expired", name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse_kick();
        kick = 1'b1;
        tick(1);
        kick = 1'b0;
    endtask

    task automatic push_xfer(input logic [31:0] a, input logic [9:0] d, input logic w);
        xfer_t x;
        x.adr = a;
        x.dat = d;
        x.we  = w;
        exp_q.push_back(x);
    endtask

    task automatic wait_acks(input int n, input string name);
        int b = 0;
        while (ack_cnt < n && b < 500) begin
            tick(1);
            b++;
        end
        if (ack_cnt < n) fail_wait(name);
    endtask

    task automatic wait_starts(input int n, input string name);
        int b = 0;
        while (start_cnt < n && b < 500) begin
            tick(1);
            b++;
        end
        if (start_cnt < n) fail_wait(name);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cyc"}, cyc_m2s, 0);
        check({tag, "_stb"}, stb_m2s, 0);
        check({tag, "_we"}, we_m2s, 0);
        check({tag, "_adr"}, adr_m2s, 0);
        check({tag, "_dat"}, dat_m2s, 0);
        check({tag, "_armed"}, armed, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_missed"}, missed, 0);
        check({tag, "_tmo_err"}, tmo_err, 0);
        check({tag, "_ref_cnt"}, ref_cnt, 0);
    endtask

    // Responder and monitor share one process so ack generation and comparison never race.
    initial begin : responder
        xfer_t cur;
        xfer_t e;
        int    lat;
        logic  prev_cyc;
        cur      = '0;
        e        = '0;
        lat      = 0;
        prev_cyc = 1'b0;
        ack_s2m  = 1'b0;
        dat_s2m  = '0;
        forever begin
            @(negedge clk);
            if (cyc_m2s === 1'b1 && !prev_cyc) begin
                start_cnt++;
                last_start_cyc = cyc_no;
                cur = {adr_m2s, dat_m2s, we_m2s};
                lat = 0;
                check("stb_with_cyc", stb_m2s, 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer: got adr=%h we=%0d, expected no transfer",
                             adr_m2s, we_m2s);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_adr", adr_m2s, e.adr);
                    check("xfer_we", we_m2s, e.we);
                    if (e.we) check("xfer_dat", dat_m2s, e.dat);
                end
            end
            if (cyc_m2s !== 1'b1 && prev_cyc) last_drop_cyc = cyc_no;
            if (ack_s2m) begin
                ack_s2m = 1'b0;
                ack_cnt++;
                last_ack_cyc = cyc_no;
                check("cyc_low_after_ack", cyc_m2s, 0);
            end else if (cyc_m2s === 1'b1 && !no_ack) begin
                if (lat >= ack_delay) begin
                    check("xfer_stable", 32'({adr_m2s, dat_m2s, we_m2s} == cur), 1);
                    ack_s2m = 1'b1;
                    dat_s2m = rd_data;
                end else begin
                    lat++;
                end
            end
            prev_cyc = (cyc_m2s === 1'b1);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL sim_timeout: bench did not finish, expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin : stimulus
        int t;
        int b;
        rst   = 1'b1;
        start = 1'b0;
        kick  = 1'b0;
        tick(3);
        check_reset_state("reset");
        rst = 1'b0;
        tick(1);

        // Arm: CR then CFG, then two polls of 7Fh without a kick.
        push_xfer(CR_ADR, 10'h0FF, 1'b1);
        push_xfer(CFG_ADR, 10'h27F, 1'b1);
        push_xfer(CR_ADR, 10'h000, 1'b0);
        push_xfer(CR_ADR, 10'h000, 1'b0);
        pulse_start();
        wait_acks(1, "arm_cr_ack");
        check("armed_before_cfg", armed, 0);
        t = last_ack_cyc;
        wait_starts(2, "cfg_start");
        check("b2b_gap_arm", last_start_cyc - t, 1);
        wait_acks(2, "arm_cfg_ack");
        check("armed_after_cfg", armed, 1);
        wait_acks(3, "poll1_ack");
        t = last_ack_cyc;
        wait_starts(4, "poll2_start");
        check("poll_interval", last_start_cyc - t, POLL_GAP);

        // Kick, then a poll in window refreshes once; the following poll must not.
        wait_acks(4, "poll2_ack");
        push_xfer(CR_ADR, 10'h000, 1'b0);
        push_xfer(CR_ADR, 10'h0FF, 1'b1);
        push_xfer(CR_ADR, 10'h000, 1'b0);
        push_xfer(CR_ADR, 10'h000, 1'b0);
        pulse_kick();
        wait_acks(5, "poll3_ack");
        t = last_ack_cyc;
        wait_starts(6, "ref1_start");
        check("b2b_gap_ref", last_start_cyc - t, 1);
        wait_acks(6, "ref1_ack");
        check("ref_cnt_1", ref_cnt, 1);
        wait_acks(8, "poll5_ack");
        check("ref_cnt_still_1", ref_cnt, 1);

        // Kick coincident with the refresh ack stays pending and causes a second refresh.
        rd_data = 10'h040;
        push_xfer(CR_ADR, 10'h000, 1'b0);
        push_xfer(CR_ADR, 10'h0FF, 1'b1);
        push_xfer(CR_ADR, 10'h000, 1'b0);
        push_xfer(CR_ADR, 10'h0FF, 1'b1);
        push_xfer(CR_ADR, 10'h000, 1'b0);
        push_xfer(CR_ADR, 10'h000, 1'b0);
        pulse_kick();
        b = 0;
        while (!(cyc_m2s === 1'b1 && we_m2s === 1'b1) && b < 500) begin
            tick(1);
            b++;
        end
        if (b >= 500) fail_wait("ref2_start");
        kick = 1'b1;
        tick(1);
        kick = 1'b0;
        wait_acks(14, "poll9_ack");
        check("ref_cnt_3", ref_cnt, 3);

        // Counter already below 40h: missed, FAULT, start and kick ignored.
        rd_data   = 10'h03F;
        ack_delay = 2;
        push_xfer(CR_ADR, 10'h000, 1'b0);
        wait_acks(15, "poll10_ack");
        ack_delay = 0;
        check("missed_set", missed, 1);
        check("fault_busy", busy, 0);
        pulse_start();
        pulse_kick();
        tick(3 * POLL_CYC);
        check("fault_no_xfer", start_cnt, 15);
        check("missed_sticky", missed, 1);
        check("fault_ref_cnt", ref_cnt, 3);

        // Reset recovers from FAULT; reset mid-transfer drops cyc on the next edge.
        rst = 1'b1;
        tick(2);
        check_reset_state("rst2");
        rst = 1'b0;
        tick(1);
        no_ack = 1'b1;
        push_xfer(CR_ADR, 10'h0FF, 1'b1);
        pulse_start();
        wait_starts(16, "noack_start");
`ifdef WWDG_FEEDER_TMO_EN
        tick(2);
`else
        tick(2 * TMO_CYC + 4);
        check("hold_without_ack", cyc_m2s, 1);
        check("tmo_err_tied", tmo_err, 0);
`endif
        rst = 1'b1;
        tick(1);
        check("rst_drops_cyc", cyc_m2s, 0);
        check("rst_drops_busy", busy, 0);
        rst = 1'b0;
        tick(2);

`ifdef WWDG_FEEDER_TMO_EN
        // No ack at all: cyc held for TMO_CYC cycles, then tmo_err and FAULT.
        push_xfer(CR_ADR, 10'h0FF, 1'b1);
        pulse_start();
        wait_starts(17, "tmo_start");
        b = 0;
        while (cyc_m2s === 1'b1 && b < 4 * TMO_CYC) begin
            tick(1);
            b++;
        end
        tick(1);
        check("tmo_cyc_len", last_drop_cyc - last_start_cyc, TMO_CYC);
        check("tmo_err_set", tmo_err, 1);
        check("tmo_missed_clear", missed, 0);
        pulse_start();
        tick(3 * POLL_CYC);
        check("tmo_no_xfer", start_cnt, 17);
        check("tmo_err_sticky", tmo_err, 1);
`endif
        no_ack = 1'b0;

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wwdg_feeder.md
WWDG_FEEDER -- requirements
Module: wwdg_feeder

Interface
REQ-001 SHALL have parameter BASE_ADR, default 32'h0110_0000, meaning the watchdog register base (CR at +0, CFG at +4, ST at +8).
REQ-002 SHALL have parameter CFG_VAL, default 10'h27F, meaning the CFG word written at start (bit9 EWI, bits8:7 prescale, bits6:0 window).
REQ-003 SHALL have parameter ARM_VAL, default 8'hFF, meaning the CR word written to enable the watchdog (bit7 WDGA).
REQ-004 SHALL have parameter REF_VAL, default 8'hFF, meaning the CR word written on each refresh.
REQ-005 SHALL have parameter POLL_CYC, default 16, meaning the idle cycles between CR polls.
REQ-006 SHALL have parameter TMO_CYC, default 8, meaning the maximum cycles to wait for an ack.
REQ-007 Ports: clk in 1, the single clock; rst in 1, the reset, synchronous and active-high.
REQ-008 Ports: start in 1, a one-cycle pulse that begins arming; kick in 1, a one-cycle pulse from the application meaning it is healthy.
REQ-009 Wishbone initiator ports: adr_m2s out 32; dat_m2s out 10; cyc_m2s out 1; stb_m2s out 1; we_m2s out 1; dat_s2m in 10; ack_s2m in 1.
REQ-010 Status ports: armed out 1; busy out 1; missed out 1 (sticky); tmo_err out 1 (sticky); ref_cnt out 16.

Function
REQ-011 SHALL implement these states: IDLE, WR_ARM, WR_CFG, WAIT, RD_CR, WR_REF, FAULT.
REQ-012 All Wishbone outputs SHALL be registered; cyc_m2s and stb_m2s SHALL be asserted together and held with adr/dat/we stable until ack_s2m is sampled high.
REQ-013 cyc_m2s SHALL drop the cycle after ack and stay low at least one cycle, so the responder returns to idle before the next transfer.
REQ-014 IDLE + start: SHALL write ARM_VAL to CR first, then CFG_VAL to CFG; the CR-before-CFG order avoids a window error while CR is still 7Fh.
REQ-015 When the WR_CFG ack arrives, armed SHALL rise, the poll counter SHALL load POLL_CYC-1, and the state SHALL go to WAIT.
REQ-016 WAIT SHALL count down to 0, then go to RD_CR, reading CR at BASE_ADR.
REQ-017 Every kick pulse SHALL set an internal kick_pend flag, in any state.
REQ-018 RD_CR ack, value D with D[6]=0: SHALL set missed and go to FAULT.
REQ-019 RD_CR ack, D[6]=1, D[6:0] <= CFG_VAL[6:0], kick_pend=1: SHALL go to WR_REF.
REQ-020 RD_CR ack, any other value: SHALL return to WAIT.
REQ-021 WR_REF SHALL write REF_VAL to CR; on its ack it SHALL clear kick_pend, increment ref_cnt (saturating at FFFFh), and return to WAIT.
REQ-022 A kick arriving in the same cycle as the WR_REF ack SHALL leave kick_pend set.
REQ-023 FAULT SHALL keep cyc_m2s low and hold until rst; start SHALL be ignored in every state except IDLE.
REQ-024 busy SHALL equal cyc_m2s.

Reset
REQ-025 On rst the block SHALL enter IDLE, with cyc/stb/we=0, adr_m2s=0, dat_m2s=0, armed=0, missed=0, tmo_err=0, ref_cnt=0, kick_pend=0.
REQ-026 rst asserted mid-transfer SHALL drop cyc_m2s on the next edge.

Configuration
REQ-027 Macro WWDG_FEEDER_TMO_EN defined: each transfer SHALL run an ack counter; if no ack arrives within TMO_CYC cycles it SHALL drop cyc, set tmo_err, and go to FAULT.
REQ-028 Macro WWDG_FEEDER_TMO_EN undefined: the block SHALL wait for ack indefinitely and tmo_err SHALL be tied 0.

Structure
REQ-029 A shared package wwdg_pkg SHALL hold the register offsets (CR 0, CFG 4, ST 8), the CR/CFG field positions, and the feeder state enum.
REQ-030 One sub-module, wb_single_xfer, SHALL handle the single-transfer handshake and the optional timeout; the feeder FSM sequences it.

Verification
REQ-031 start, responder acks after 1 cycle -> write CR=0FFh to adr 01100000h, then CFG=27Fh to adr 01100004h; armed=1.
REQ-032 Poll returns 7Fh with window 7Fh and kick seen -> write CR=0FFh; ref_cnt=1; kick_pend cleared.
REQ-033 Poll returns 7Fh, no kick -> no write; return to WAIT; next poll occurs after POLL_CYC cycles.
REQ-034 Poll returns 3Fh (bit6=0) -> missed=1; FAULT; no further cyc.
REQ-035 With WWDG_FEEDER_TMO_EN defined and no ack for 8 cycles -> cyc drops; tmo_err=1; FAULT.
REQ-036 Back-to-back transfers -> cyc_m2s is low for at least 1 cycle between each ack and the next cyc.
